// File: rtl/axi_stream_pkg.sv
// Shared state encoding, AXI constants and sizing helper for the read-stream test master.
// Pure declarations: no latency or backpressure of its own.
package axi_stream_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  function automatic logic [2:0] size_from_width(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/addr_fifo.sv
// Generic synchronous FIFO; pop_dat shows the head combinationally (zero read latency).
// Backpressure: push is dropped when full and pop ignored when empty; the owner keeps within bounds.
module addr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/axi_read_stream_mo.sv
// AXI4 multi-outstanding INCR read master with in-order RLAST/RID/RRESP checking; AR issued the cycle after start.
// Backpressure: AR held stable until ARREADY, RREADY high whenever bursts are outstanding; AXI_READ_STREAM_MO_CHECK_EN adds a data check.
module axi_read_stream_mo
  import axi_stream_pkg::*;
#(
  parameter int DATA_W          = 512,
  parameter int ADDR_W          = 32,
  parameter int ID_W            = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        burst_length,
  input  logic [CNT_W-1:0]  num_bursts,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bursts_done,
  output logic              err_last,
  output logic              err_resp,
  output logic              err_id,
  input  logic              ARREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [ID_W-1:0]   ARID,
  output logic [7:0]        ARLEN,
  output logic              ARVALID,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic [1:0]        ARLOCK,
  output logic [3:0]        ARCACHE,
  output logic [2:0]        ARPROT,
  output logic              RREADY,
  input  logic [ID_W-1:0]   RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID
`ifdef AXI_READ_STREAM_MO_CHECK_EN
  ,
  output logic              err_data,
  output logic [CNT_W-1:0]  err_count
`endif
);

  localparam logic [2:0] SIZE_LOG = size_from_width(DATA_W);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

  state_t state, state_nxt;
  logic [7:0]        len_q;
  logic [CNT_W-1:0]  num_q, issued;
  logic [OUT_W-1:0]  outstanding;
  logic [8:0]        beat, len_beats;
  logic [ID_W-1:0]   exp_id;
  logic [ADDR_W-1:0] addr_step;
  logic ar_hs, r_hs, last_exp, burst_end, done_nxt, start_ok;

  assign len_beats = (len_q == 8'd0) ? 9'd256 : {1'b0, len_q};
  assign addr_step = ADDR_W'(len_beats) << SIZE_LOG;
  assign ar_hs     = ARVALID && ARREADY;
  assign r_hs      = RVALID && RREADY;
  assign last_exp  = (beat == len_beats - 9'd1);
  // A beat closes the burst on RLAST or on reaching the expected length (resync).
  assign burst_end = r_hs && (RLAST || last_exp);
  assign start_ok  = (state == S_IDLE) && start;

  assign ARLEN   = len_q - 8'd1;
  assign ARSIZE  = SIZE_LOG;
  assign ARBURST = BURST_INCR;
  assign ARLOCK  = 2'b00;
  assign ARCACHE = 4'b0000;
  assign ARPROT  = 3'b000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    done_nxt  = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) begin
          if (num_bursts == '0) done_nxt = 1'b1;
          else                  state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        ARVALID = (issued < num_q) && (outstanding < MAX_OUT);
        RREADY  = (outstanding != '0);
        if (ARVALID && ARREADY && ((issued + CNT_W'(1)) == num_q)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        RREADY = (outstanding != '0);
        if ((outstanding == '0) && (bursts_done == num_q)) begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done        <= 1'b0;
      len_q       <= '0;
      num_q       <= '0;
      issued      <= '0;
      outstanding <= '0;
      beat        <= '0;
      bursts_done <= '0;
      exp_id      <= '0;
      ARADDR      <= '0;
      ARID        <= '0;
      err_last    <= 1'b0;
      err_resp    <= 1'b0;
      err_id      <= 1'b0;
    end else begin
      done <= done_nxt;
      if (start_ok) begin
        len_q       <= burst_length;
        num_q       <= num_bursts;
        ARADDR      <= base_addr;
        ARID        <= '0;
        exp_id      <= '0;
        issued      <= '0;
        outstanding <= '0;
        beat        <= '0;
        bursts_done <= '0;
        err_last    <= 1'b0;
        err_resp    <= 1'b0;
        err_id      <= 1'b0;
      end else if (state != S_IDLE) begin
        if (ar_hs) begin
          issued <= issued + CNT_W'(1);
          ARADDR <= ARADDR + addr_step;
          ARID   <= ARID + ID_W'(1);
        end
        case ({ar_hs, burst_end})
          2'b10:   outstanding <= outstanding + OUT_W'(1);
          2'b01:   outstanding <= outstanding - OUT_W'(1);
          default: outstanding <= outstanding;
        endcase
        if (r_hs) begin
          if (burst_end) begin
            beat        <= '0;
            bursts_done <= bursts_done + CNT_W'(1);
            exp_id      <= exp_id + ID_W'(1);
          end else begin
            beat <= beat + 9'd1;
          end
          if (RLAST != last_exp)   err_last <= 1'b1;
          if (RID != exp_id)       err_id   <= 1'b1;
          if (RRESP != RESP_OKAY)  err_resp <= 1'b1;
        end
      end
    end
  end

`ifdef AXI_READ_STREAM_MO_CHECK_EN
  localparam int LANES = DATA_W / 32;

  logic [ADDR_W-1:0] burst_addr;
  logic [31:0]       beat_base;
  logic              fifo_empty, mism, chk_bad;

  addr_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ADDR_W)
  ) u_addr_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (ar_hs),
    .push_dat (ARADDR),
    .pop      (burst_end),
    .pop_dat  (burst_addr),
    .empty    (fifo_empty)
  );

  assign beat_base = 32'(burst_addr) + (32'(beat) << SIZE_LOG);

  // Each 32-bit lane carries its own byte address.
  always_comb begin
    mism = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (RDATA[32*k +: 32] != beat_base + 32'(4 * k)) mism = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_bad   <= 1'b0;
      err_data  <= 1'b0;
      err_count <= '0;
    end else if (start_ok) begin
      chk_bad   <= 1'b0;
      err_data  <= 1'b0;
      err_count <= '0;
    end else begin
      chk_bad <= r_hs && !fifo_empty && mism;
      if (chk_bad) begin
        err_data <= 1'b1;
        if (err_count != '1) err_count <= err_count + CNT_W'(1);
      end
    end
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^RDATA;
`endif

endmodule

// File: tb/tb_axi_read_stream_mo.sv
// Directed bench for axi_read_stream_mo with a queue-based in-order AXI read slave.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_axi_read_stream_mo;

  localparam int DATA_W = 512;
  localparam int ADDR_W = 32;
  localparam int ID_W   = 4;
  localparam int MAXO   = 4;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [7:0]        burst_length;
  logic [CNT_W-1:0]  num_bursts;
  logic              busy, done, err_last, err_resp, err_id;
  logic [CNT_W-1:0]  bursts_done;
  logic              ARREADY, ARVALID, RREADY, RLAST, RVALID;
  logic [ADDR_W-1:0] ARADDR;
  logic [ID_W-1:0]   ARID, RID;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE, ARPROT;
  logic [1:0]        ARBURST, ARLOCK, RRESP;
  logic [3:0]        ARCACHE;
  logic [DATA_W-1:0] RDATA;
`ifdef AXI_READ_STREAM_MO_CHECK_EN
  logic              err_data;
  logic [CNT_W-1:0]  err_count;
`endif

  axi_read_stream_mo #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .MAX_OUTSTANDING(MAXO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .burst_length(burst_length), .num_bursts(num_bursts), .busy(busy), .done(done),
    .bursts_done(bursts_done), .err_last(err_last), .err_resp(err_resp), .err_id(err_id),
    .ARREADY(ARREADY), .ARADDR(ARADDR), .ARID(ARID), .ARLEN(ARLEN), .ARVALID(ARVALID),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT),
    .RREADY(RREADY), .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID)
`ifdef AXI_READ_STREAM_MO_CHECK_EN
    , .err_data(err_data), .err_count(err_count)
`endif
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
  } ar_t;

  ar_t rq[$];
  ar_t arlog[$];
  ar_t ar_q;
  int  n_cmp = 0;
  int  n_bad = 0;
  int  sb_beat = 0;
  int  sent_bursts = 0;
  int  beat_total = 0;
  int  done_cnt = 0;
  int  stab_viol = 0;
  int  r_allow = 1000000;
  bit  rand_ar = 0;
  int  early_burst = -1, early_beat = -1;
  int  resp_burst = -1, resp_beat = -1;
  bit  corrupt = 0;
  bit  ar_hs_q = 0, r_hs_q = 0, r_last_q = 0, prev_stall = 0;
  logic [ADDR_W-1:0] prev_addr;
  logic [ID_W-1:0]   prev_id;
  logic [7:0]        prev_len;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // In-order slave: records accepted ARs, returns address-pattern data.
  initial begin
    ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RID = '0; RRESP = '0; RDATA = '0;
    forever begin
      @(negedge clk);
      if (ar_hs_q) begin rq.push_back(ar_q); arlog.push_back(ar_q); end
      if (r_hs_q) begin
        beat_total++;
        if (r_last_q) begin void'(rq.pop_front()); sb_beat = 0; sent_bursts++; end
        else sb_beat++;
      end
      if (done) done_cnt++;
      ARREADY = rand_ar ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rq.size() > 0 && sent_bursts < r_allow) begin
        RVALID = 1'b1;
        RID    = rq[0].id;
        RLAST  = (sb_beat == int'(rq[0].len)) ||
                 (sent_bursts == early_burst && sb_beat == early_beat);
        RRESP  = (sent_bursts == resp_burst && sb_beat == resp_beat) ? 2'b10 : 2'b00;
        for (int k = 0; k < DATA_W / 32; k++)
          RDATA[32*k +: 32] = rq[0].addr + 32'(sb_beat * (DATA_W / 8)) + 32'(4 * k);
        if (corrupt && sent_bursts == 0 && sb_beat == 1) RDATA[64] = ~RDATA[64];
      end else begin
        RVALID = 1'b0;
        RLAST  = 1'b0;
      end
      #1;
      if (prev_stall && (!ARVALID || ARADDR != prev_addr || ARID != prev_id || ARLEN != prev_len))
        stab_viol++;
      prev_stall = ARVALID && !ARREADY;
      prev_addr = ARADDR; prev_id = ARID; prev_len = ARLEN;
      ar_hs_q  = ARVALID && ARREADY;
      ar_q     = '{ARADDR, ARID, ARLEN};
      r_hs_q   = RVALID && RREADY;
      r_last_q = RLAST;
      if (reset) begin
        rq.delete(); sb_beat = 0; ar_hs_q = 0; r_hs_q = 0; prev_stall = 0; RVALID = 1'b0;
      end
    end
  end

  task automatic kick(input logic [31:0] b, input logic [7:0] l, input logic [15:0] n);
    arlog.delete(); sent_bursts = 0; beat_total = 0; done_cnt = 0;
    base_addr = b; burst_length = l; num_bursts = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int c = 0; c < 20000 && done_cnt == 0; c++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  logic [31:0] exp_addr [4];

  initial begin
    exp_addr[0] = 32'h1000; exp_addr[1] = 32'h1400; exp_addr[2] = 32'h1800; exp_addr[3] = 32'h1C00;
    reset = 1'b1; start = 1'b0; base_addr = '0; burst_length = '0; num_bursts = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_rready", RREADY, 0);
    chk("rst_araddr", ARADDR, 0);
    chk("rst_bursts_done", bursts_done, 0);
    chk("rst_errs", {err_last, err_resp, err_id}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("arsize", ARSIZE, 6);
    chk("arburst", ARBURST, 1);

    // Basic four-burst run
    kick(32'h1000, 8'd16, 16'd4);
    wait_done("basic");
    chk("basic_ar_count", arlog.size(), 4);
    for (int i = 0; i < 4 && i < arlog.size(); i++) begin
      chk($sformatf("basic_araddr%0d", i), arlog[i].addr, exp_addr[i]);
      chk($sformatf("basic_arid%0d", i), arlog[i].id, i);
      chk($sformatf("basic_arlen%0d", i), arlog[i].len, 15);
    end
    chk("basic_bursts_done", bursts_done, 4);
    chk("basic_errs", {err_last, err_resp, err_id}, 0);
    chk("basic_beats", beat_total, 64);
`ifdef AXI_READ_STREAM_MO_CHECK_EN
    chk("basic_err_data", err_data, 0);
`endif

    // Outstanding limit while R is withheld
    r_allow = 0;
    kick(32'h0, 8'd4, 16'd8);
    repeat (20) @(negedge clk);
    chk("hold_ar_count", arlog.size(), 4);
    chk("hold_arvalid", ARVALID, 0);
    chk("hold_rready", RREADY, 1);
    r_allow = 1;
    repeat (20) @(negedge clk);
    chk("hold_ar_after_one", arlog.size(), 5);
    chk("hold_arvalid2", ARVALID, 0);
    if (arlog.size() > 4) chk("hold_ar5_addr", arlog[4].addr, 32'h400);
    r_allow = 1000000;
    wait_done("hold");
    chk("hold_bursts_done", bursts_done, 8);

    // Random ARREADY: AR payload must hold during stalls
    rand_ar = 1; stab_viol = 0;
    kick(32'h2000, 8'd2, 16'd12);
    wait_done("rand");
    rand_ar = 0;
    chk("rand_stable", stab_viol, 0);
    chk("rand_bursts_done", bursts_done, 12);
    if (arlog.size() == 12) chk("rand_last_addr", arlog[11].addr, 32'h2580);
    chk("rand_errs", {err_last, err_resp, err_id}, 0);

    // Early RLAST on beat 3 of an 8-beat burst
    early_burst = 0; early_beat = 3;
    kick(32'h3000, 8'd8, 16'd2);
    wait_done("early");
    early_burst = -1; early_beat = -1;
    chk("early_err_last", err_last, 1);
    chk("early_bursts_done", bursts_done, 2);
    chk("early_err_resp", err_resp, 0);

    // Error response on one beat; flags from the previous run cleared by start
    resp_burst = 0; resp_beat = 5;
    kick(32'h3000, 8'd8, 16'd1);
    wait_done("resp");
    resp_burst = -1; resp_beat = -1;
    chk("resp_err_resp", err_resp, 1);
    chk("resp_err_last", err_last, 0);

    // Zero bursts: done the cycle after start, no AR
    kick(32'h5000, 8'd4, 16'd0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    @(negedge clk);
    chk("zero_done_low", done, 0);
    chk("zero_ar_count", arlog.size(), 0);

    // Length 0 means 256 beats
    kick(32'h10000, 8'd0, 16'd1);
    wait_done("len256");
    if (arlog.size() > 0) chk("len256_arlen", arlog[0].len, 255);
    chk("len256_beats", beat_total, 256);
    chk("len256_err_last", err_last, 0);

`ifdef AXI_READ_STREAM_MO_CHECK_EN
    corrupt = 1;
    kick(32'h6000, 8'd4, 16'd2);
    wait_done("corrupt");
    corrupt = 0;
    chk("corrupt_err_data", err_data, 1);
    chk("corrupt_err_count", err_count, 1);
`endif

    // Reset with bursts in flight
    r_allow = 0;
    kick(32'h4000, 8'd4, 16'd8);
    repeat (10) @(negedge clk);
    chk("mid_outstanding", arlog.size(), 4);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_arvalid", ARVALID, 0);
    chk("mid_rst_rready", RREADY, 0);
    chk("mid_rst_bursts_done", bursts_done, 0);
    chk("mid_rst_araddr", ARADDR, 0);
    chk("mid_rst_arid", ARID, 0);
    reset = 1'b0;
    r_allow = 1000000;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_read_stream_mo.md
Name: axi_read_stream_mo

Overview:
- Parametrised AXI4 read master for DDR4 bandwidth and soak tests.
- On `start`, issues `num_bursts` INCR bursts from `base_addr`, with up to MAX_OUTSTANDING addresses in flight.
- Drains all read data and checks protocol conformance on every returned beat (RLAST position, RID order, RRESP).
- Sits between the test sequencer and the MIG AXI slave port; replaces the single-outstanding read streamer.

Parameters:
- DATA_W, 512: RDATA width in bits; power of two, 32..1024.
- ADDR_W, 32: ARADDR width.
- ID_W, 4: ARID/RID width.
- MAX_OUTSTANDING, 4: maximum accepted-but-incomplete bursts; 1..16.
- CNT_W, 16: width of the burst counters and `num_bursts`.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in S_IDLE
- base_addr  in  ADDR_W  first burst address; latched on start
- burst_length  in  8  beats per burst, 1..255; 0 means 256; latched on start
- num_bursts  in  CNT_W  number of bursts; latched on start
- busy  out  1  high while not in S_IDLE
- done  out  1  one-cycle pulse when the run completes
- bursts_done  out  CNT_W  bursts fully received in the current run
- err_last  out  1  sticky: RLAST early or missing
- err_resp  out  1  sticky: RRESP != 0 on any beat
- err_id  out  1  sticky: RID differs from the expected in-order ID
- ARREADY  in  1
- ARADDR  out  ADDR_W
- ARID  out  ID_W
- ARLEN  out  8
- ARVALID  out  1
- ARSIZE  out  3  constant log2(DATA_W/8)
- ARBURST  out  2  constant 2'b01
- ARLOCK  out  2  constant 0
- ARCACHE  out  4  constant 0
- ARPROT  out  3  constant 0
- RREADY  out  1
- RID  in  ID_W
- RDATA  in  DATA_W
- RRESP  in  2
- RLAST  in  1
- RVALID  in  1

Behaviour:
- Reset values: state S_IDLE; all counters 0; `busy`, `done`, `ARVALID`, `RREADY` and all error flags 0; `ARADDR` 0; `ARID` 0.
- Reset asserted mid-run clears everything immediately; any in-flight AXI transaction is abandoned. The slave must be reset alongside.
- S_IDLE:
  - `start`=1 latches `base_addr`, `burst_length` and `num_bursts`, clears the error flags and `bursts_done`.
  - If `num_bursts`=0: pulse `done` on the next cycle and stay in S_IDLE.
  - Otherwise go to S_RUN.
  - `start` is ignored in every state except S_IDLE.
- S_RUN:
  - `ARVALID`=1 while issued < num_bursts and outstanding < MAX_OUTSTANDING.
  - Once asserted, `ARVALID`, `ARADDR`, `ARID` and `ARLEN` stay stable until ARREADY.
  - On an AR handshake: issued += 1; ARADDR += len_beats*(DATA_W/8), wrapping modulo 2^ADDR_W; ARID += 1, wrapping modulo 2^ID_W.
  - ARLEN = len_beats-1.
  - When issued = num_bursts, go to S_DRAIN.
- `RREADY` = (outstanding != 0) in S_RUN and S_DRAIN; 0 in S_IDLE.
- Outstanding counter: +1 on an AR handshake, -1 on an R handshake with RLAST, unchanged if both happen in the same cycle. It never exceeds MAX_OUTSTANDING.
- Beat counter, per R handshake:
  - RLAST=1 with beat != len_beats-1 → set `err_last`.
  - beat = len_beats-1 with RLAST=0 → set `err_last` and treat the beat as last (resync).
  - On a last beat: beat resets to 0, `bursts_done` += 1, expected RID += 1.
  - RID != expected RID → set `err_id`. Slave responses are required in order.
  - RRESP != 0 → set `err_resp`.
- S_DRAIN: when outstanding = 0 and `bursts_done` = num_bursts, pulse `done` for one cycle and go to S_IDLE.
- Counter widths:
  - Outstanding counter: clog2(MAX_OUTSTANDING+1) bits.
  - Beat counter: 9 bits.
  - Address arithmetic in ADDR_W.
- 4 KB boundary: crossings are not split. The caller aligns `base_addr` and picks `burst_length` accordingly.
- An AR handshake and the final R beat in the same cycle are both accounted in that cycle.

Optional Feature:
- Macro: AXI_READ_STREAM_MO_CHECK_EN.
- When defined:
  - Adds output `err_data` (1 bit, sticky, cleared on start) and output `err_count` (CNT_W bits, saturating).
  - Each 32-bit lane k of every beat must equal the byte address of that lane: burst addr + beat*(DATA_W/8) + 4k.
  - Any mismatching beat sets `err_data` and increments `err_count` by 1.
  - The comparison is registered one stage, so flags update one cycle after the beat.
  - A FIFO of depth MAX_OUTSTANDING holds the issued burst addresses.
- When not defined: these ports, the comparator and the FIFO are absent.

Decomposition:
- Package `axi_stream_pkg`:
  - State enum {S_IDLE, S_RUN, S_DRAIN}.
  - AXI constants: BURST_INCR=2'b01, RESP_OKAY=2'b00.
  - Function `size_from_width(DATA_W)`.
- Sub-module `addr_fifo`: synchronous FIFO, depth MAX_OUTSTANDING, width ADDR_W; used only under AXI_READ_STREAM_MO_CHECK_EN.

Test Plan:
- base=0x1000, len=16, num=4, MAX_OUTSTANDING=4, ARREADY=1, zero-latency slave → 4 ARs at 0x1000/0x1400/0x1800/0x1C00 with ARID 0..3, ARLEN=15; `done` pulses once; `bursts_done`=4; no errors.
- Slave withholds R data, ARREADY=1, num=8, MAX_OUTSTANDING=2 → exactly 2 ARs accepted before ARVALID drops; the third AR is issued only after the first RLAST.
- ARREADY toggled randomly → ARADDR/ARID/ARLEN stable while ARVALID=1 and ARREADY=0.
- Slave asserts RLAST on beat 3 of a len=8 burst → `err_last`=1 and the run still completes. Separately, RRESP=2'b10 on one beat → `err_resp`=1.
- num=0 → `done` one cycle after start, no ARVALID. Separately, len=0 → ARLEN=255 and 256 beats accepted.
- reset asserted with 3 bursts outstanding → next edge shows `busy`=0, `ARVALID`=0, `RREADY`=0, counters 0. With AXI_READ_STREAM_MO_CHECK_EN, one corrupted lane → `err_data`=1 and `err_count`=1.
